// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one word-level serial transmit lane among REQ_NUM requesters.
// Each grant goes out as a header word carrying the requester ID, then payload words, then an idle gap.
module serial_tx_arbiter #(
  parameter real         TCQ           = 0.1,
  parameter int          DATA_WIDTH    = 32,
  parameter int          REQ_NUM       = 4,
  parameter int          MAX_BURST     = 16,
  parameter int          GAP_CYCLES    = 8,
  parameter int          STALL_TIMEOUT = 64,
  parameter logic [15:0] HDR_MAGIC     = 16'hA55A
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [REQ_NUM-1:0]            req_vld_i,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data_i,
  input  logic [REQ_NUM-1:0]            req_last_i,
  output logic [REQ_NUM-1:0]            req_rdy_o,
  output logic                          tx_vld_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  input  logic                          tx_rdy_i,
  output logic [2:0]                    grant_id_o,
  output logic                          busy_o,
  output logic                          trunc_o,
  output logic                          abort_o
);

  // state   | meaning
  // IDLE    | no grant; round-robin search from rr_ptr
  // HEADER  | presenting the header word for grant_id_o
  // PAYLOAD | granted requester passed straight through to the lane
  // GAP     | lane held idle so the far end drops word alignment
  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_GAP} state_t;

  localparam int              WCNT_W   = $clog2(MAX_BURST + 1);
  localparam int              SCNT_W   = $clog2(STALL_TIMEOUT + 1);
  localparam logic [7:0]      GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [WCNT_W-1:0] WCNT_TC = WCNT_W'(MAX_BURST - 1);
  localparam logic [SCNT_W-1:0] SCNT_TC = SCNT_W'(STALL_TIMEOUT - 1);

  if (DATA_WIDTH < 32) begin : g_bad_width
    $error("DATA_WIDTH must be at least 32");
  end
  if (REQ_NUM < 2 || REQ_NUM > 8) begin : g_bad_req_num
    $error("REQ_NUM must be 2..8");
  end
  if (MAX_BURST < 1 || STALL_TIMEOUT < 1) begin : g_bad_limits
    $error("MAX_BURST and STALL_TIMEOUT must be at least 1");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("GAP_CYCLES must be 0..255");
  end
  if (TCQ < 0.0) begin : g_bad_tcq
    $error("TCQ must be non-negative");
  end

  state_t                state;
  logic [2:0]            rr_ptr;
  logic [WCNT_W-1:0]     word_cnt;
  logic [SCNT_W-1:0]     stall_cnt;
  logic [7:0]            gap_cnt;
  logic                  hdr_vld;
  logic [DATA_WIDTH-1:0] hdr_data;

  // Requester inputs widened to 8 entries so a 3-bit index always fits.
  logic [7:0]            vld_ext;
  logic [7:0]            last_ext;
  logic [DATA_WIDTH-1:0] word_ext [8];

  always_comb begin
    vld_ext  = '0;
    last_ext = '0;
    vld_ext[REQ_NUM-1:0]  = req_vld_i;
    last_ext[REQ_NUM-1:0] = req_last_i;
    for (int k = 0; k < 8; k++) begin
      word_ext[k] = '0;
      if (k < REQ_NUM) word_ext[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Scan offsets from the highest down so the nearest set index above rr_ptr wins.
  logic [2:0] arb_idx;
  logic       arb_hit;
  logic [3:0] cand;

  always_comb begin
    arb_idx = '0;
    arb_hit = 1'b0;
    cand    = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + 4'(i);
      if (cand >= 4'(REQ_NUM)) cand = cand - 4'(REQ_NUM);
      if (vld_ext[cand[2:0]]) begin
        arb_hit = 1'b1;
        arb_idx = cand[2:0];
      end
    end
  end

  logic        in_payload;
  logic        pay_xfer;
  logic [31:0] hdr_word;
  logic [7:0]  rdy_ext;

  assign in_payload = (state == ST_PAYLOAD);
  assign pay_xfer   = in_payload && vld_ext[grant_id_o] && tx_rdy_i;
  assign hdr_word   = {HDR_MAGIC, 5'b0, arb_idx, 8'h00};

  always_comb begin
    rdy_ext = '0;
    if (in_payload) rdy_ext[grant_id_o] = tx_rdy_i;
    req_rdy_o = rdy_ext[REQ_NUM-1:0];
    tx_vld_o  = in_payload ? vld_ext[grant_id_o]  : hdr_vld;
    tx_data_o = in_payload ? word_ext[grant_id_o] : hdr_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      word_cnt   <= '0;
      stall_cnt  <= '0;
      gap_cnt    <= '0;
      hdr_vld    <= 1'b0;
      hdr_data   <= '0;
      grant_id_o <= '0;
      busy_o     <= 1'b0;
      trunc_o    <= 1'b0;
      abort_o    <= 1'b0;
    end else begin
      trunc_o <= 1'b0;
      abort_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (arb_hit) begin
            grant_id_o <= arb_idx;
            word_cnt   <= '0;
            stall_cnt  <= '0;
            hdr_vld    <= 1'b1;
            hdr_data   <= DATA_WIDTH'(hdr_word);
            busy_o     <= 1'b1;
            state      <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (tx_rdy_i) begin
            hdr_vld  <= 1'b0;
            hdr_data <= '0;
            rr_ptr   <= (grant_id_o == 3'(REQ_NUM - 1)) ? 3'd0 : grant_id_o + 3'd1;
            state    <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (pay_xfer) begin
            stall_cnt <= '0;
            word_cnt  <= word_cnt + 1'b1;
            if (last_ext[grant_id_o]) begin
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
            end else if (word_cnt == WCNT_TC) begin
              trunc_o <= 1'b1;
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
            end
          end else if (!vld_ext[grant_id_o]) begin
            if (stall_cnt == SCNT_TC) begin
              abort_o <= 1'b1;
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end else begin
            stall_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 8'd0) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: requester word queues feed the DUT, the lane is logged,
// and each step compares against hand-computed frames and timings.
module tb_serial_tx_arbiter;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int DW = 32;
  localparam int RN = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [RN-1:0]    req_vld = '0;
  logic [RN-1:0]    req_last = '0;
  logic [RN*DW-1:0] req_data = '0;
  logic [RN-1:0]    req_rdy;
  logic             tx_vld;
  logic [DW-1:0]    tx_data;
  logic             tx_rdy = 1'b1;
  logic [2:0]       grant_id;
  logic             busy, trunc, abort;

  always #5 clk = ~clk;

  serial_tx_arbiter #(
    .TCQ(0.1), .DATA_WIDTH(DW), .REQ_NUM(RN), .MAX_BURST(16),
    .GAP_CYCLES(8), .STALL_TIMEOUT(64), .HDR_MAGIC(16'hA55A)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_vld_i(req_vld), .req_data_i(req_data), .req_last_i(req_last), .req_rdy_o(req_rdy),
    .tx_vld_o(tx_vld), .tx_data_o(tx_data), .tx_rdy_i(tx_rdy),
    .grant_id_o(grant_id), .busy_o(busy), .trunc_o(trunc), .abort_o(abort)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t       src_q [RN][$];
  logic [31:0] tx_log [$];
  int          log_cyc [$];
  logic [31:0] exp_q [$];
  int          cyc = 0;
  int          trunc_cnt = 0, abort_cnt = 0, trunc_cyc = -1, abort_cyc = -1;
  int          nvec = 0, nerr = 0;
  logic [RN-1:0] hs;
  logic [31:0] held;
  logic        hold_pend;

  // Sample just before each rising edge; update requester drives just after it.
  always begin
    @(negedge clk);
    #4;
    cyc++;
    hs = '0;
    if (!rst) begin
      hs = req_vld & req_rdy;
      if (tx_vld && tx_rdy) begin
        tx_log.push_back(tx_data);
        log_cyc.push_back(cyc);
      end
      if (trunc) begin trunc_cnt++; trunc_cyc = cyc; end
      if (abort) begin abort_cnt++; abort_cyc = cyc; end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < RN; k++) begin
      if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      if (src_q[k].size() > 0) begin
        req_vld[k]            = 1'b1;
        req_data[k*DW +: DW]  = src_q[k][0].data;
        req_last[k]           = src_q[k][0].last;
      end else begin
        req_vld[k]            = 1'b0;
        req_data[k*DW +: DW]  = '0;
        req_last[k]           = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] d, input logic l);
    word_t w;
    w.data = d;
    w.last = l;
    src_q[k].push_back(w);
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && tx_log.size() < n; i++) @(negedge clk);
    chk(tag, 64'(tx_log.size()), 64'(n));
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, 64'(tx_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 64'(tx_log[i]), 64'(exp_q[i]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < RN; k++) src_q[k].delete();
    @(negedge clk);
    rst = 1'b0;
    tx_log.delete();
    log_cyc.delete();
    exp_q.delete();
    trunc_cnt = 0; abort_cnt = 0; trunc_cyc = -1; abort_cyc = -1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tx_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_vld", 64'(tx_vld), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_trunc", 64'(trunc), 64'd0);
    chk("rst_abort", 64'(abort), 64'd0);
    rst = 1'b0;

    // 1: single 3-word packet from requester 1, then an 8-cycle gap
    push(1, 32'h11, 1'b0); push(1, 32'h22, 1'b0); push(1, 32'h33, 1'b1);
    wait_log(4, 60, "t1_wait");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_gap_busy%0d", i), 64'(busy), 64'd1);
      chk($sformatf("t1_gap_vld%0d", i), 64'(tx_vld), 64'd0);
      @(negedge clk);
    end
    chk("t1_busy_fall", 64'(busy), 64'd0);
    chk("t1_grant", 64'(grant_id), 64'd1);
    exp_q = '{32'hA55A0100, 32'h11, 32'h22, 32'h33};
    chk_log("t1_log");
    chk("t1_trunc", 64'(trunc_cnt), 64'd0);

    // 2: requesters 0,2,3 all busy with 1-word packets -> fair rotation
    do_reset();
    for (int j = 0; j < 2; j++) begin
      push(0, 32'h100 + 32'(j), 1'b1);
      push(2, 32'h200 + 32'(j), 1'b1);
      push(3, 32'h300 + 32'(j), 1'b1);
    end
    wait_log(12, 300, "t2_wait");
    exp_q = '{32'hA55A0000, 32'h100, 32'hA55A0200, 32'h200, 32'hA55A0300, 32'h300,
              32'hA55A0000, 32'h101, 32'hA55A0200, 32'h201, 32'hA55A0300, 32'h301};
    chk_log("t2_log");

    // 3: 20-word packet split by MAX_BURST into 16 + 4
    do_reset();
    for (int j = 1; j <= 20; j++) push(0, 32'h1000 + 32'(j), (j == 20));
    wait_log(22, 300, "t3_wait");
    exp_q.delete();
    exp_q.push_back(32'hA55A0000);
    for (int j = 1; j <= 16; j++) exp_q.push_back(32'h1000 + 32'(j));
    exp_q.push_back(32'hA55A0000);
    for (int j = 17; j <= 20; j++) exp_q.push_back(32'h1000 + 32'(j));
    chk_log("t3_log");
    repeat (12) @(negedge clk);
    chk("t3_trunc_cnt", 64'(trunc_cnt), 64'd1);
    chk("t3_abort_cnt", 64'(abort_cnt), 64'd0);
    chk("t3_trunc_when", 64'(trunc_cyc - log_cyc[16]), 64'd1);

    // 4: lane backpressure; header held, then tx_rdy alternates
    do_reset();
    tx_rdy = 1'b0;
    push(1, 32'h41, 1'b0); push(1, 32'h42, 1'b0); push(1, 32'h43, 1'b0); push(1, 32'h44, 1'b1);
    for (int i = 0; i < 20 && !tx_vld; i++) @(negedge clk);
    chk("t4_hdr_vld", 64'(tx_vld), 64'd1);
    chk("t4_hdr", 64'(tx_data), 64'hA55A0100);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("t4_hdr_hold%0d", i), 64'({tx_vld, tx_data}), 64'({1'b1, 32'hA55A0100}));
    end
    hold_pend = 1'b0;
    held = '0;
    for (int i = 0; i < 30; i++) begin
      tx_rdy = (i % 2 == 0);
      #1;
      chk("t4_other_rdy", 64'(req_rdy & 4'b1101), 64'd0);
      if (tx_vld && tx_data[31:16] != 16'hA55A)
        chk("t4_rdy_track", 64'(req_rdy[1]), 64'(tx_rdy));
      if (hold_pend) chk("t4_word_hold", 64'({tx_vld, tx_data}), 64'({1'b1, held}));
      hold_pend = tx_vld && !tx_rdy;
      held = tx_data;
      @(negedge clk);
    end
    tx_rdy = 1'b1;
    exp_q = '{32'hA55A0100, 32'h41, 32'h42, 32'h43, 32'h44};
    chk_log("t4_log");

    // 5: requester 2 stalls after 2 words -> abort, then pending requester 3
    do_reset();
    push(2, 32'h21, 1'b0); push(2, 32'h22, 1'b0);
    wait_log(1, 30, "t5_hdr_wait");
    push(3, 32'h301, 1'b1);
    wait_log(5, 300, "t5_wait");
    exp_q = '{32'hA55A0200, 32'h21, 32'h22, 32'hA55A0300, 32'h301};
    chk_log("t5_log");
    chk("t5_abort_cnt", 64'(abort_cnt), 64'd1);
    chk("t5_trunc_cnt", 64'(trunc_cnt), 64'd0);
    chk("t5_abort_when", 64'(abort_cyc - log_cyc[2]), 64'd65);
    chk("t5_grant", 64'(grant_id), 64'd3);

    // 6: reset in the middle of a payload
    do_reset();
    push(2, 32'h61, 1'b0); push(2, 32'h62, 1'b0); push(2, 32'h63, 1'b0); push(2, 32'h64, 1'b1);
    wait_log(2, 30, "t6_wait");
    rst = 1'b1;
    src_q[2].delete();
    @(negedge clk);
    chk("t6_tx_vld", 64'(tx_vld), 64'd0);
    chk("t6_tx_data", 64'(tx_data), 64'd0);
    chk("t6_req_rdy", 64'(req_rdy), 64'd0);
    chk("t6_grant", 64'(grant_id), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_pulses", 64'({trunc, abort}), 64'd0);
    rst = 1'b0;
    tx_log.delete();
    log_cyc.delete();
    push(3, 32'h81, 1'b1);
    push(0, 32'h71, 1'b1);
    wait_log(4, 100, "t6_after_wait");
    exp_q = '{32'hA55A0000, 32'h71, 32'hA55A0300, 32'h81};
    chk_log("t6_log");
    chk("t6_no_pulses", 64'(trunc_cnt + abort_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
